// File: rtl/microwave_timer_ctrl.sv
// Microwave cooking timer sequencer: keypad BCD time entry (M:ST:SU), one-second
// countdown with door interlock, pause/resume and clear; drives magnetron and done.
module microwave_timer_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] minutes,
    output logic [3:0] second_tens,
    output logic [3:0] second_units,
    output logic       mag_on,
    output logic       done,
    output logic       busy
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSet,
        StCook,
        StPause,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    min_q, min_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    units_q, units_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          mag_on_q, mag_on_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic       key_ok;
    logic       shift_ok;
    logic       time_nonzero;
    logic       tick;
    logic       last_sec;
    logic [3:0] dec_min, dec_tens, dec_units;

    assign key_ok       = key_valid && (key_digit <= 4'd9);
    // Refusing a shift while units > 5 keeps the tens digit a legal 0..5.
    assign shift_ok     = key_ok && (units_q <= 4'd5);
    assign time_nonzero = (min_q != 4'd0) || (tens_q != 4'd0) || (units_q != 4'd0);
    assign tick         = (presc_q == PrescLast);
    assign last_sec     = (min_q == 4'd0) && (tens_q == 4'd0) && (units_q == 4'd1);

    // BCD one-second decrement with borrow chain units -> tens -> minutes.
    always_comb begin
        dec_min   = min_q;
        dec_tens  = tens_q;
        dec_units = units_q;
        if (units_q != 4'd0) begin
            dec_units = units_q - 4'd1;
        end else begin
            dec_units = 4'd9;
            if (tens_q != 4'd0) begin
                dec_tens = tens_q - 4'd1;
            end else begin
                dec_tens = 4'd5;
                dec_min  = min_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        units_d = units_q;
        presc_d = '0;

        unique case (state_q)
            StIdle: begin
                if (key_ok) begin
                    state_d = StSet;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    units_d = key_digit;
                end
            end
            StSet: begin
                if (stop_clear) begin
                    state_d = StIdle;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                end else if (start && door_closed && time_nonzero) begin
                    state_d = StCook;
                end else if (shift_ok) begin
                    min_d   = tens_q;
                    tens_d  = units_q;
                    units_d = key_digit;
                end
            end
            StCook: begin
                if (stop_clear || !door_closed) begin
                    state_d = StPause;
                end else if (tick) begin
                    if (last_sec) begin
                        state_d = StDone;
                        min_d   = 4'd0;
                        tens_d  = 4'd0;
                        units_d = 4'd0;
                    end else begin
                        min_d   = dec_min;
                        tens_d  = dec_tens;
                        units_d = dec_units;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            StPause: begin
                if (stop_clear) begin
                    state_d = StIdle;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                end else if (start && door_closed) begin
                    state_d = StCook;
                end
            end
            StDone: begin
                min_d   = 4'd0;
                tens_d  = 4'd0;
                units_d = 4'd0;
                if (stop_clear || !door_closed) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                min_d   = 4'd0;
                tens_d  = 4'd0;
                units_d = 4'd0;
            end
        endcase

        // Flags are derived from the next state so they register alongside it.
        mag_on_d = (state_d == StCook);
        done_d   = (state_d == StDone);
        busy_d   = (state_d == StCook) || (state_d == StPause);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            min_q    <= 4'd0;
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            presc_q  <= '0;
            mag_on_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            tens_q   <= tens_d;
            units_q  <= units_d;
            presc_q  <= presc_d;
            mag_on_q <= mag_on_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign minutes      = min_q;
    assign second_tens  = tens_q;
    assign second_units = units_q;
    assign mag_on       = mag_on_q;
    assign done         = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed bench for microwave_timer_ctrl with TICKS_PER_SEC = 4.
module tb_microwave_timer_ctrl;

    localparam int unsigned TPS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop_clear;
    logic       door_closed;
    logic [3:0] minutes;
    logic [3:0] second_tens;
    logic [3:0] second_units;
    logic       mag_on;
    logic       done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    microwave_timer_ctrl #(
        .TICKS_PER_SEC(TPS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_digit   (key_digit),
        .start       (start),
        .stop_clear  (stop_clear),
        .door_closed (door_closed),
        .minutes     (minutes),
        .second_tens (second_tens),
        .second_units(second_units),
        .mag_on      (mag_on),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_clear = 1'b1;
        step();
        stop_clear = 1'b0;
    endtask

    function automatic logic [15:0] tm();
        return {4'h0, minutes, second_tens, second_units};
    endfunction

    function automatic logic [15:0] flags();
        return {13'd0, mag_on, done, busy};
    endfunction

    initial begin
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        start       = 1'b0;
        stop_clear  = 1'b0;
        door_closed = 1'b1;
        step(2);
        reset = 1'b0;
        check("reset_time", tm(), 16'h0000);
        check("reset_flags", flags(), 16'h0000);

        // Idle ignores start
        pulse_start();
        check("idle_start_ignored", flags(), 16'h0000);

        // Entry rules
        key(4'd7);
        check("key7", tm(), 16'h0007);
        key(4'd2);
        check("key2_rejected", tm(), 16'h0007);
        key(4'd12);
        check("key12_ignored", tm(), 16'h0007);
        pulse_stop();
        check("set_clear_time", tm(), 16'h0000);
        key(4'd12);
        check("idle_key12", tm(), 16'h0000);
        key(4'd1);
        key(4'd2);
        key(4'd3);
        check("entry_123", tm(), 16'h0123);
        key(4'd4);
        check("entry_234", tm(), 16'h0234);
        pulse_stop();
        check("entry_cleared", tm(), 16'h0000);

        // Full 1:30 countdown
        key(4'd1);
        key(4'd3);
        key(4'd0);
        check("set_130", tm(), 16'h0130);
        pulse_start();
        check("cook_flags", flags(), 16'h0005);
        step(TPS - 1);
        check("before_first_tick", tm(), 16'h0130);
        step();
        check("first_tick", tm(), 16'h0129);
        step(90 * TPS - TPS - 1);
        check("one_before_done_time", tm(), 16'h0001);
        check("one_before_done_flags", flags(), 16'h0005);
        step();
        check("done_time", tm(), 16'h0000);
        check("done_flags", flags(), 16'h0002);
        pulse_start();
        check("done_start_ignored", flags(), 16'h0002);
        pulse_stop();
        check("done_clear_flags", flags(), 16'h0000);

        // Borrow chain
        key(4'd1);
        key(4'd0);
        key(4'd0);
        pulse_start();
        step(TPS);
        check("borrow_100_059", tm(), 16'h0059);
        step(49 * TPS);
        check("reach_010", tm(), 16'h0010);
        step(TPS);
        check("borrow_010_009", tm(), 16'h0009);

        // Door interlock
        door_closed = 1'b0;
        step();
        check("door_open_flags", flags(), 16'h0001);
        check("door_open_time", tm(), 16'h0009);
        pulse_start();
        check("start_door_open", flags(), 16'h0001);
        door_closed = 1'b1;
        step(2);
        check("closed_no_start", flags(), 16'h0001);
        pulse_start();
        check("resume_flags", flags(), 16'h0005);
        step(TPS - 1);
        check("resume_hold", tm(), 16'h0009);
        step();
        check("resume_tick", tm(), 16'h0008);

        // stop_clear in COOK pauses, second one clears
        pulse_stop();
        check("stop_pause_flags", flags(), 16'h0001);
        check("stop_pause_time", tm(), 16'h0008);
        pulse_stop();
        check("stop_idle_flags", flags(), 16'h0000);
        check("stop_idle_time", tm(), 16'h0000);

        // Tick and door-open on the same edge
        key(4'd5);
        pulse_start();
        step(TPS - 1);
        door_closed = 1'b0;
        step();
        check("tick_door_time", tm(), 16'h0005);
        check("tick_door_flags", flags(), 16'h0001);
        door_closed = 1'b1;
        pulse_start();
        step(TPS);
        check("after_resume_tick", tm(), 16'h0004);

        // Reset mid-cook
        step();
        reset = 1'b1;
        step();
        check("midcook_reset_time", tm(), 16'h0000);
        check("midcook_reset_flags", flags(), 16'h0000);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
